// File: rtl/approx_mult_sweep_monitor_if.sv
// approx_mult_sweep_monitor_if: operand/product and result bundle of the sweep engine
interface approx_mult_sweep_monitor_if #(
  parameter int W = 8
);
  logic start;
  logic [W-1:0] a_out;
  logic [W-1:0] b_out;
  logic [2*W-1:0] p_in;
  logic busy;
  logic done;
  logic [2*W:0] err_count;
  logic [4*W-1:0] sum_ed;
  logic [2*W-1:0] max_ed;
  logic fail_seen;
  logic [W-1:0] first_fail_a;
  logic [W-1:0] first_fail_b;
  modport master (
    input start, p_in,
    output a_out, b_out, busy, done, err_count, sum_ed, max_ed, fail_seen, first_fail_a, first_fail_b
  );
  modport slave (
    output start, p_in,
    input a_out, b_out, busy, done, err_count, sum_ed, max_ed, fail_seen, first_fail_a, first_fail_b
  );
endinterface

// File: rtl/approx_mult_sweep_monitor.sv
// approx_mult_sweep_monitor: exhaustive error-distance sweep of a WxW approximate multiplier
module approx_mult_sweep_monitor #(
  parameter int W = 8
) (
  input logic clk,
  input logic rst,
  approx_mult_sweep_monitor_if.master m
);
  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;
  state_t state, state_nxt;
  logic [2*W-1:0] cnt, cnt_inc, p1, exact, ed;
  logic [W-1:0] a1, b1;
  logic pv, v1, go;
  assign go = m.start && (state == IDLE || state == DONE);
  assign cnt_inc = cnt + (2*W)'(1);
  assign exact = (2*W)'(a1) * (2*W)'(b1);
  assign ed = exact >= p1 ? exact - p1 : p1 - exact;
  assign m.a_out = cnt[2*W-1:W];
  assign m.b_out = cnt[W-1:0];
  always_comb begin
    state_nxt = go ? SWEEP : (state == SWEEP && &cnt_inc) ? DRAIN : (state == DRAIN && !pv) ? DONE : state;
    m.busy = state == SWEEP || state == DRAIN;
    m.done = state == DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // pv marks the pair now on a_out/b_out as part of the sweep; it stays set through the first DRAIN cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      pv <= 1'b0;
      v1 <= 1'b0;
      p1 <= '0;
      a1 <= '0;
      b1 <= '0;
      m.err_count <= '0;
      m.sum_ed <= '0;
      m.max_ed <= '0;
      m.fail_seen <= 1'b0;
      m.first_fail_a <= '0;
      m.first_fail_b <= '0;
    end else begin
      pv <= state_nxt == SWEEP || state == SWEEP;
      v1 <= pv;
      p1 <= m.p_in;
      a1 <= m.a_out;
      b1 <= m.b_out;
      if (go) begin
        cnt <= '0;
        m.err_count <= '0;
        m.sum_ed <= '0;
        m.max_ed <= '0;
        m.fail_seen <= 1'b0;
        m.first_fail_a <= '0;
        m.first_fail_b <= '0;
      end else begin
        if (state == SWEEP) cnt <= cnt_inc;
        if (v1) begin
          m.sum_ed <= m.sum_ed + (4*W)'(ed);
          m.err_count <= m.err_count + (2*W+1)'(ed != '0);
          if (ed > m.max_ed) m.max_ed <= ed;
          if (ed != '0 && !m.fail_seen) begin
            m.fail_seen <= 1'b1;
            m.first_fail_a <= a1;
            m.first_fail_b <= b1;
          end
        end
      end
    end
endmodule

// File: tb/tb_approx_mult_sweep_monitor.sv
// tb_approx_mult_sweep_monitor: scoreboard bench driving fixed and random approximate multipliers
module tb_approx_mult_sweep_monitor;
  localparam int W = 4;
  localparam int N = 1 << (2*W);
  typedef struct {
    longint err, sum, mx, fail, fa, fb, t0;
  } exp_t;
  typedef struct {
    int md, mask, off, ra, rb, flip;
  } cfg_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  cfg_t cfg;
  exp_t q[$];
  logic done_q = 1'b0;
  approx_mult_sweep_monitor_if #(.W(W)) bus();
  approx_mult_sweep_monitor #(.W(W)) dut (.clk(clk), .rst(rst), .m(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int approx(cfg_t c, int a, int b);
    int e = a * b;
    return c.md == 0 ? e : c.md == 1 ? (e & ~1) : c.md == 2 ? 0 : c.md == 3 ? N - 1 :
           c.md == 4 ? (e & ~c.mask) : c.md == 5 ? (e + c.off) % N :
           ((a & c.ra) == c.ra && (b & c.rb) == c.rb) ? (e ^ c.flip) : e;
  endfunction
  assign bus.p_in = (2*W)'(approx(cfg, int'(bus.a_out), int'(bus.b_out)));
  function automatic cfg_t mk(int md);
    cfg_t c = '{default: 0};
    c.md = md;
    return c;
  endfunction
  function automatic exp_t model(cfg_t c);
    exp_t x = '{default: 0};
    for (int a = 0; a < (1 << W); a++)
      for (int b = 0; b < (1 << W); b++) begin
        longint e = longint'(a * b);
        longint p = longint'(approx(c, a, b));
        longint d = e > p ? e - p : p - e;
        x.sum += d;
        if (d > x.mx) x.mx = d;
        if (d != 0) begin
          x.err++;
          if (x.fail == 0) begin
            x.fail = 1;
            x.fa = a;
            x.fb = b;
          end
        end
      end
    return x;
  endfunction
  task automatic chk(string n, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", n, act, exp);
    end
  endtask
  function automatic longint all_outs();
    return longint'({bus.busy, bus.done, bus.a_out, bus.b_out, bus.err_count, bus.sum_ed,
                     bus.max_ed, bus.fail_seen, bus.first_fail_a, bus.first_fail_b});
  endfunction
  always @(negedge clk) begin
    exp_t x;
    if (!rst) chk("busy_done_excl", longint'(bus.busy & bus.done), 0);
    if (bus.done && !done_q) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        x = q.pop_front();
        chk("latency", longint'(cyc) - x.t0, N + 1);
        chk("err_count", longint'(bus.err_count), x.err);
        chk("sum_ed", longint'(bus.sum_ed), x.sum);
        chk("max_ed", longint'(bus.max_ed), x.mx);
        chk("fail_seen", longint'(bus.fail_seen), x.fail);
        chk("first_fail_a", longint'(bus.first_fail_a), x.fa);
        chk("first_fail_b", longint'(bus.first_fail_b), x.fb);
        chk("a_hold", longint'(bus.a_out), (1 << W) - 1);
        chk("b_hold", longint'(bus.b_out), (1 << W) - 1);
      end
    end
    done_q = bus.done;
  end
  task automatic wait_done();
    for (int t = 0; t < N + 20 && !bus.done; t++) @(negedge clk);
    chk("sweep_done", longint'(bus.done), 1);
    if (!bus.done) q.delete();
  endtask
  task automatic run(cfg_t c, exp_t x, bit poke);
    cfg = c;
    x.t0 = longint'(cyc) + 1;
    q.push_back(x);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", longint'(bus.busy), 1);
    chk("done_after_start", longint'(bus.done), 0);
    chk("zeroed_on_start", longint'({bus.err_count, bus.sum_ed, bus.max_ed, bus.fail_seen}), 0);
    if (poke) begin
      repeat (4) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    wait_done();
  endtask
  initial begin
    cfg_t c;
    cfg = mk(0);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", all_outs(), 0);
    rst = 1'b0;
    run(mk(0), '{0, 0, 0, 0, 0, 0, 0}, 1'b1);
    run(mk(1), '{64, 64, 1, 1, 1, 1, 0}, 1'b0);
    run(mk(2), '{225, 14400, 225, 1, 1, 1, 0}, 1'b0);
    run(mk(3), '{256, 50880, 255, 1, 0, 0, 0}, 1'b0);
    cfg = mk(2);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (100) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("async_reset_outputs", all_outs(), 0);
    @(negedge clk);
    rst = 1'b0;
    run(mk(2), '{225, 14400, 225, 1, 1, 1, 0}, 1'b0);
    repeat (6) begin
      c.md = $urandom_range(4, 6);
      c.mask = $urandom_range(1, N / 16 - 1);
      c.off = $urandom_range(1, 300);
      c.ra = $urandom_range(0, (1 << W) - 1);
      c.rb = $urandom_range(0, (1 << W) - 1);
      c.flip = 1 << $urandom_range(0, 2*W - 1);
      run(c, model(c), 1'b0);
    end
    repeat (2) @(negedge clk);
    chk("queue_drained", longint'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
